// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  localparam logic [31:0] DBZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Shared 32-bit add/subtract datapath: Result = A + (B ^ {32{Sub}}) + Sub.
module addsub32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Sub,
  output logic [31:0] Result,
  output logic        CarryOut
);

  logic [32:0] sum;

  assign sum = {1'b0, A} + {1'b0, B ^ {32{Sub}}} + {32'd0, Sub};
  assign {CarryOut, Result} = sum;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer driving HI/LO over one shared adder.
// Signed MULT/DIV support is compiled in only when MULDIV_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 32 shift-add / restoring-subtract iterations
// FIX   | sign correction and HI/LO write
// DONE  | done pulse; start here is accepted back-to-back
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;
  logic             dz_q;
  logic             dz_wait_q;
  logic [31:0]      acc_q;
  logic [31:0]      wlo_q;
  logic [31:0]      opnd_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  op_e         op_in;
  logic        in_div;
  logic        in_dz;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign op_in  = op_e'(op);
  assign in_div = (op_in == OP_DIVU) || (op_in == OP_DIV);
  assign in_dz  = in_div && (b == 32'd0);

`ifdef MULDIV_SIGNED_EN
  logic in_signed;
  logic in_neg_a;
  logic in_neg_b;
  logic neg_q;
  logic neg_rem_q;

  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_neg_a  = in_signed & a[31];
  assign in_neg_b  = in_signed & b[31];
  assign a_mag     = neg_if(a, in_neg_a);
  assign b_mag     = neg_if(b, in_neg_b);
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Divide: acc_q is the remainder, wlo_q the quotient; multiply: acc_q:wlo_q is the product.
  logic [32:0] rem_sh;
  logic [31:0] add_a;
  logic [31:0] add_res;
  logic        add_co;

  assign rem_sh = {acc_q, wlo_q[31]};
  assign add_a  = div_q ? rem_sh[31:0] : acc_q;

  addsub32 u_addsub (
    .A        (add_a),
    .B        (opnd_q),
    .Sub      (div_q),
    .Result   (add_res),
    .CarryOut (add_co)
  );

  logic [32:0] mul_sum;
  logic        div_ok;
  logic [31:0] acc_d;
  logic [31:0] wlo_d;

  // rem_sh[32] set means the shifted remainder already exceeds any 32-bit divisor.
  always_comb begin
    mul_sum = wlo_q[0] ? {add_co, add_res} : {1'b0, acc_q};
    div_ok  = add_co | rem_sh[32];
    acc_d   = mul_sum[32:1];
    wlo_d   = {mul_sum[0], wlo_q[31:1]};
    if (div_q) begin
      acc_d = div_ok ? add_res : rem_sh[31:0];
      wlo_d = {wlo_q[30:0], div_ok};
    end
  end

  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

`ifdef MULDIV_SIGNED_EN
  assign prod_fix = neg_q ? (~{acc_q, wlo_q} + 64'd1) : {acc_q, wlo_q};
  assign quot_fix = neg_if(wlo_q, neg_q);
  assign rem_fix  = neg_if(acc_q, neg_rem_q);
`else
  assign prod_fix = {acc_q, wlo_q};
  assign quot_fix = wlo_q;
  assign rem_fix  = acc_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      dz_wait_q <= 1'b0;
      acc_q     <= '0;
      wlo_q     <= '0;
      opnd_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= in_dz ? FIX : RUN;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            div_q     <= in_div;
            dz_q      <= in_dz;
            dz_wait_q <= in_dz;
            // Raw dividend parked in acc_q so divide-by-zero can return it on hi.
            acc_q     <= in_dz ? a : 32'd0;
            wlo_q     <= in_div ? a_mag : b_mag;
            opnd_q    <= in_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= in_neg_a ^ in_neg_b;
            neg_rem_q <= in_neg_a;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          wlo_q <= wlo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // Divide-by-zero lingers one extra FIX cycle so done lands two edges after start.
          if (dz_wait_q) begin
            dz_wait_q <= 1'b0;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (dz_q) begin
              hi_q  <= acc_q;
              lo_q  <= DBZ_LO;
              dbz_q <= 1'b1;
            end else if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[63:32];
              lo_q <= prod_fix[31:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: arithmetic reference model checked every cycle plus directed literals.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic.
  function automatic void ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint sx, sy, p, q, r;
    bit     sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    sy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    rz = 1'b0;
    rh = '0;
    rl = '0;
    if (!o[0]) begin
      p  = sx * sy;
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == 32'd0) begin
      rh = x;
      rl = 32'hFFFF_FFFF;
      rz = 1'b1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  // Cycle-level model: one op in flight, 33 edges to done (2 for divide by zero).
  logic        m_busy, m_done, m_dbz, p_dbz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        ref_result(op, a, b, p_hi, p_lo, p_dbz);
        m_busy = 1'b1;
        m_dbz  = 1'b0;
        m_left = (op[0] && b == 32'd0) ? 2 : 33;
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_ctrl", {61'd0, busy, done, dbz}, {61'd0, m_busy, m_done, m_dbz});
      check("cycle_hilo", {hi, lo}, {m_hi, m_lo});
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
  endtask

  // lat = edges after the start-sampling edge until done; bc = cycles with busy high.
  task automatic wait_done(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat = i - 1;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL wait_done: done not seen within 100 cycles");
    end
  endtask

  task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el);
    int lat, bc;
    @(negedge clk);
    launch(o, x, y);
    wait_done(lat, bc);
    check({name, "_lat"}, 64'(lat), (o[0] && y == 32'd0) ? 64'd2 : 64'd33);
    check({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  int lat, bc;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, dbz}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    // Full-scale unsigned multiply with latency and busy width.
    @(negedge clk);
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    check("multu_max_lat", 64'(lat), 64'd33);
    check("multu_max_busy", 64'(bc), 64'd33);
    check("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("multu_max_lo", {32'd0, lo}, 64'h1);

    run_vec("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14);
    check("divu_100_7_dbz", {63'd0, dbz}, 64'd0);
    run_vec("multu_shift", 2'b00, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);
    run_vec("divu_big_div", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1);
    run_vec("divu_self", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_vec("divu_small", 2'b01, 32'd7, 32'hFFFF_FFFF, 32'd7, 32'd0);
    run_vec("multu_zero", 2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);

`ifdef MULDIV_SIGNED_EN
    run_vec("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_vec("mult_m1_2", 2'b10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_vec("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_vec("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_vec("mult_min_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
`else
    run_vec("mult_m1_2", 2'b10, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
    run_vec("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);
`endif

    // Divide by zero, then a fresh start clears the flag.
    @(negedge clk);
    launch(2'b01, 32'd5, 32'd0);
    wait_done(lat, bc);
    check("dz_lat", 64'(lat), 64'd2);
    check("dz_hi", {32'd0, hi}, 64'd5);
    check("dz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("dz_flag", {63'd0, dbz}, 64'd1);
    @(negedge clk);
    launch(2'b00, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("dz_clear", {63'd0, dbz}, 64'd0);
    wait_done(lat, bc);
    check("after_dz_lo", {hi, lo}, 64'd12);

    // Start held during RUN with other operands is ignored.
    @(negedge clk);
    launch(2'b01, 32'd1000, 32'd10);
    @(posedge clk);
    #1;
    launch(2'b00, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("ignore_hilo", {hi, lo}, 64'd100);

    // Back-to-back: start raised in the DONE cycle.
    launch(2'b00, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat, bc);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_hilo", {hi, lo}, 64'h1_0000_0000);

    // Reset during iteration 10 aborts and clears HI/LO.
    @(negedge clk);
    launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    run_vec("post_abort", 2'b01, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
